// File: rtl/pattern_gen.sv
// Video test-pattern generator: colour bars, checkerboard, scrolling bars, solid colour.
// Frame config (mode, colour, scroll offset) latches at pixel (0,0); pixel outputs are registered.
module pattern_gen #(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int CW          = 1,
  parameter int BAR_SHIFT   = 7,
  parameter int CHK_SHIFT   = 5,
  parameter int SCROLL_STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          EA,
  input  logic [10:0]   count_h,
  input  logic [10:0]   count_v,
  input  logic [1:0]    mode,
  input  logic [2:0]    solid_rgb,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue,
  output logic [7:0]    frame_cnt
);

  typedef struct packed {
    logic [1:0]  mode;
    logic [2:0]  solid;
    logic [10:0] offset;
  } frame_cfg_t;

  frame_cfg_t  cfg_q, cfg_d, cfg_eff;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [2:0]  rgb_q, rgb_d;
  logic        frame_start, active;
  logic [10:0] scroll_h, bar_h, chk_x;

  function automatic logic [2:0] palette(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b100;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b010;
      3'd3:    c = 3'b011;
      3'd4:    c = 3'b001;
      3'd5:    c = 3'b101;
      3'd6:    c = 3'b111;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  always_comb begin
    frame_start = (count_h == 11'd0) && (count_v == 11'd0);
    cfg_d       = cfg_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start) begin
      cfg_d.mode   = mode;
      cfg_d.solid  = solid_rgb;
      cfg_d.offset = cfg_q.offset + 11'(SCROLL_STEP);
      frame_cnt_d  = frame_cnt_q + 8'd1;
    end
    // Pixel (0,0) already uses the freshly latched values so a frame never mixes configs.
    cfg_eff  = cfg_d;
    active   = EA && ({1'b0, count_h} < 12'(H_ACTIVE)) && ({1'b0, count_v} < 12'(V_ACTIVE));
    scroll_h = count_h + cfg_eff.offset;
    bar_h    = (cfg_eff.mode == 2'd2) ? scroll_h : count_h;
    chk_x    = (count_h >> CHK_SHIFT) ^ (count_v >> CHK_SHIFT);
    rgb_d    = 3'b000;
    if (active) begin
      case (cfg_eff.mode)
        2'd0, 2'd2: rgb_d = palette(3'(bar_h >> BAR_SHIFT));
        2'd1:       rgb_d = {3{chk_x[0]}};
        default:    rgb_d = cfg_eff.solid;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q       <= '0;
      frame_cnt_q <= '0;
      rgb_q       <= '0;
    end else begin
      cfg_q       <= cfg_d;
      frame_cnt_q <= frame_cnt_d;
      rgb_q       <= rgb_d;
    end
  end

  assign red       = {CW{rgb_q[2]}};
  assign green     = {CW{rgb_q[1]}};
  assign blue      = {CW{rgb_q[0]}};
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: three parameterisations share one stimulus stream and
// are checked every cycle against a frame-level model, plus literal spot checks.
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n, EA;
  logic [10:0] count_h, count_v;
  logic [1:0]  mode;
  logic [2:0]  solid_rgb;

  logic       ra, ga, ba, rc, gc, bc;
  logic [3:0] rb, gb, bb;
  logic [7:0] fca, fcb, fcc;

  int nvec = 0;
  int nerr = 0;
  bit done = 1'b0;

  // Model state: latched frame config, per-instance scroll offset, frame count.
  int         m_frames, m_mode, m_solid;
  int         m_off [3];
  int         steps [3] = '{1, 1, 512};
  logic [2:0] exp_rgb [3];
  logic [7:0] exp_fc;

  always #5 clk = ~clk;

  pattern_gen u_a (
    .clk(clk), .rst_n(rst_n), .EA(EA), .count_h(count_h), .count_v(count_v),
    .mode(mode), .solid_rgb(solid_rgb), .red(ra), .green(ga), .blue(ba), .frame_cnt(fca));

  pattern_gen #(.CW(4)) u_b (
    .clk(clk), .rst_n(rst_n), .EA(EA), .count_h(count_h), .count_v(count_v),
    .mode(mode), .solid_rgb(solid_rgb), .red(rb), .green(gb), .blue(bb), .frame_cnt(fcb));

  pattern_gen #(.SCROLL_STEP(512)) u_c (
    .clk(clk), .rst_n(rst_n), .EA(EA), .count_h(count_h), .count_v(count_v),
    .mode(mode), .solid_rgb(solid_rgb), .red(rc), .green(gc), .blue(bc), .frame_cnt(fcc));

  function automatic logic [2:0] bar_colour(input int i);
    case (i)
      0: return 3'b100;
      1: return 3'b110;
      2: return 3'b010;
      3: return 3'b011;
      4: return 3'b001;
      5: return 3'b101;
      6: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] model_rgb(input int h, input int v, input bit ea,
                                           input int md, input int sol, input int off);
    if (!ea || h >= 1024 || v >= 768) return 3'b000;
    case (md)
      0: return bar_colour((h / 128) % 8);
      1: return (((h / 32) + (v / 32)) % 2 == 1) ? 3'b111 : 3'b000;
      2: return bar_colour((((h + off) % 2048) / 128) % 8);
      default: return 3'(sol);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Present one pixel; expectations become visible to the checker at the sampling edge.
  task automatic pix(input int h, input int v, input bit ea);
    logic [2:0] e [3];
    count_h = 11'(h);
    count_v = 11'(v);
    EA      = ea;
    if (h == 0 && v == 0) begin
      m_mode   = int'(mode);
      m_solid  = int'(solid_rgb);
      for (int k = 0; k < 3; k++) m_off[k] = (m_off[k] + steps[k]) % 2048;
      m_frames = (m_frames + 1) % 256;
    end
    for (int k = 0; k < 3; k++) e[k] = model_rgb(h, v, ea, m_mode, m_solid, m_off[k]);
    @(posedge clk);
    exp_rgb = e;
    exp_fc  = 8'(m_frames);
    #1;
  endtask

  task automatic hit_reset();
    EA = 1'b0; count_h = 11'd1500; count_v = 11'd1500;
    rst_n = 1'b0;
    exp_rgb = '{default: 3'b000};
    exp_fc = 8'd0;
    m_frames = 0; m_mode = 0; m_solid = 0;
    m_off = '{default: 0};
  endtask

  task automatic do_reset();
    hit_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (done) break;
      chk("a_rgb", 16'({ra, ga, ba}), 16'(exp_rgb[0]));
      chk("b_rgb", 16'({rb, gb, bb}),
          16'({{4{exp_rgb[1][2]}}, {4{exp_rgb[1][1]}}, {4{exp_rgb[1][0]}}}));
      chk("c_rgb", 16'({rc, gc, bc}), 16'(exp_rgb[2]));
      chk("a_fc", 16'(fca), 16'(exp_fc));
      chk("b_fc", 16'(fcb), 16'(exp_fc));
      chk("c_fc", 16'(fcc), 16'(exp_fc));
    end
  end

  initial begin
    mode = 2'd0; solid_rgb = 3'b000;
    hit_reset();
    #2;
    chk("reset_rgb_a", 16'({ra, ga, ba}), 16'h0);
    chk("reset_fc_a", 16'(fca), 16'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model itself.
    chk("model_bar127", 16'(model_rgb(127, 10, 1, 0, 0, 0)), 16'(3'b100));
    chk("model_bar128", 16'(model_rgb(128, 10, 1, 0, 0, 0)), 16'(3'b110));
    chk("model_chk", 16'(model_rgb(32, 32, 1, 1, 0, 0)), 16'(3'b000));
    chk("model_scroll", 16'(model_rgb(125, 5, 1, 2, 0, 3)), 16'(3'b110));

    // Bars sweep on one line.
    mode = 2'd0;
    pix(0, 0, 1);
    for (int h = 0; h < 1024; h++) begin
      pix(h, 10, 1);
      case (h)
        0, 127: chk("bars_red", 16'({ra, ga, ba}), 16'(3'b100));
        128:    chk("bars_yel", 16'({ra, ga, ba}), 16'(3'b110));
        256:    chk("bars_grn", 16'({ra, ga, ba}), 16'(3'b010));
        896, 1023: chk("bars_blk", 16'({ra, ga, ba}), 16'(3'b000));
        default: ;
      endcase
    end

    // Black override.
    pix(299, 10, 1);
    pix(300, 10, 0);
    chk("ea_low", 16'({ra, ga, ba}), 16'h0);
    pix(1100, 10, 1);
    chk("h_blank", 16'({ra, ga, ba}), 16'h0);
    pix(5, 800, 1);
    chk("v_blank", 16'({ra, ga, ba}), 16'h0);

    // Mid-frame mode change waits for the next frame start.
    mode = 2'd1;
    pix(0, 100, 1);
    chk("midframe_bars", 16'({ra, ga, ba}), 16'(3'b100));
    pix(130, 767, 1);
    chk("midframe_bars2", 16'({ra, ga, ba}), 16'(3'b110));
    pix(0, 0, 1);
    chk("chk_00", 16'({ra, ga, ba}), 16'h0);
    chk("fc_plus1", 16'(fca), 16'd2);
    pix(32, 0, 1);  chk("chk_32_0", 16'({ra, ga, ba}), 16'(3'b111));
    pix(32, 32, 1); chk("chk_32_32", 16'({ra, ga, ba}), 16'h0);
    pix(0, 63, 1);  chk("chk_0_63", 16'({ra, ga, ba}), 16'(3'b111));
    pix(0, 64, 1);  chk("chk_0_64", 16'({ra, ga, ba}), 16'h0);

    // Scrolling bars: offset 3 (step 1) and 1536 (step 512) after three frames.
    do_reset();
    mode = 2'd2;
    repeat (3) pix(0, 0, 1);
    pix(124, 5, 1);  chk("scroll_124", 16'({ra, ga, ba}), 16'(3'b100));
    pix(125, 5, 1);  chk("scroll_125", 16'({ra, ga, ba}), 16'(3'b110));
    pix(1020, 5, 1); chk("scroll_1020", 16'({ra, ga, ba}), 16'h0);
    pix(0, 5, 1);    chk("scroll512_off1536", 16'({rc, gc, bc}), 16'(3'b001));
    pix(0, 0, 1);    chk("scroll512_wrap", 16'({rc, gc, bc}), 16'(3'b100));
    pix(124, 5, 1);  chk("scroll_off4", 16'({ra, ga, ba}), 16'(3'b110));

    // Frame counter wrap; EA toggling must not matter.
    for (int k = 0; k < 251; k++) pix(0, 0, k[0]);
    chk("fc_255", 16'(fca), 16'd255);
    pix(0, 0, 0);
    chk("fc_wrap", 16'(fca), 16'd0);
    chk("fs_ea_low_blk", 16'({ra, ga, ba}), 16'h0);

    // Solid colour on the CW=4 instance, then reset mid-line.
    do_reset();
    mode = 2'd3; solid_rgb = 3'b101;
    pix(0, 0, 1);
    pix(50, 50, 1);
    chk("solid_cw4", 16'({rb, gb, bb}), 16'h0F0F);
    solid_rgb = 3'b010;
    pix(51, 50, 1);
    chk("solid_held", 16'({rb, gb, bb}), 16'h0F0F);
    pix(60, 50, 1);
    #2;
    hit_reset();
    #1;
    chk("async_rst_b", 16'({rb, gb, bb}), 16'h0);
    chk("async_rst_a", 16'({ra, ga, ba}), 16'h0);
    chk("async_rst_fc", 16'({fca, fcb}), 16'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    mode = 2'd2;
    pix(0, 0, 1);
    chk("post_rst_fc", 16'(fcc), 16'd1);
    chk("post_rst_off512", 16'({rc, gc, bc}), 16'(3'b001));
    chk("post_rst_off1", 16'({ra, ga, ba}), 16'(3'b100));

    done = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
